// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT input-stage constants, types and the bit-reversal helper.
package fft_pkg;
    localparam int FFT_N      = 8;
    localparam int FFT_BITS   = 3;
    localparam int FFT_DATA_W = 16;
    localparam int MAX_BITS   = 16;

    typedef logic bank_t;

    typedef struct packed {
        logic [FFT_DATA_W-1:0] re;
        logic [FFT_DATA_W-1:0] im;
    } cplx_t;

    // Reverses the low `bits` bits of addr; higher bits come back as zero.
    function automatic logic [MAX_BITS-1:0] bitrev(input logic [MAX_BITS-1:0] addr, input int bits);
        bitrev = '0;
        for (int i = 0; i < MAX_BITS; i++)
            if (i < bits) bitrev[bits-1-i] = addr[i];
    endfunction
endpackage

// File: rtl/pingpong_bank_ctrl.sv
// pingpong_bank_ctrl: tracks which of two sample banks are filling, full and next to hand off.
module pingpong_bank_ctrl
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  frame_done,
    input  logic  frame_ack,
    output bank_t fill_bank,
    output logic  frame_valid,
    output bank_t frame_bank,
    output logic  bank_free
);
    logic [1:0] r_full;
    bank_t      r_read_bank;
    logic       r_pending;
    bank_t      r_pend_bank;

    assign frame_valid = r_full[r_read_bank];
    assign frame_bank  = r_read_bank;
    assign bank_free   = !r_full[fill_bank];

    // The completed bank is marked full one cycle late so its last write lands first.
    always_ff @(posedge clk)
        if (rst) begin
            r_full      <= '0;
            r_read_bank <= '0;
            r_pending   <= 1'b0;
            r_pend_bank <= '0;
            fill_bank   <= '0;
        end else begin
            r_pending <= frame_done;
            if (frame_done) begin
                r_pend_bank <= fill_bank;
                fill_bank   <= ~fill_bank;
            end
            if (frame_valid && frame_ack) begin
                r_full[r_read_bank] <= 1'b0;
                r_read_bank         <= ~r_read_bank;
            end
            if (r_pending) r_full[r_pend_bank] <= 1'b1;
        end
endmodule

// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: writes natural-order complex samples to ping-pong banks at bit-reversed addresses.
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int N            = FFT_N,
    parameter int BITS_PER_ROW = FFT_BITS,
    parameter int DATA_W       = FFT_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_re,
    input  logic [DATA_W-1:0]       in_im,
    input  logic                    in_last,
    output logic                    wr_en,
    output logic                    wr_bank,
    output logic [BITS_PER_ROW-1:0] wr_addr,
    output logic [DATA_W-1:0]       wr_re,
    output logic [DATA_W-1:0]       wr_im,
    output logic                    frame_valid,
    output logic                    frame_bank,
    input  logic                    frame_ack,
    output logic                    frame_err
);
    logic [BITS_PER_ROW-1:0] r_cnt;
    logic                    w_accept;
    logic                    w_cnt_last;
    logic                    w_bank_free;
    bank_t                   w_fill_bank;

    assign in_ready   = !rst && w_bank_free;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_last = r_cnt == BITS_PER_ROW'(N - 1);

    pingpong_bank_ctrl u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (w_accept && w_cnt_last),
        .frame_ack   (frame_ack),
        .fill_bank   (w_fill_bank),
        .frame_valid (frame_valid),
        .frame_bank  (frame_bank),
        .bank_free   (w_bank_free)
    );

    // Framing is purely by count; in_last is only compared, never used to resync.
    always_ff @(posedge clk)
        if (rst) begin
            r_cnt     <= '0;
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_re     <= '0;
            wr_im     <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= w_accept;
            frame_err <= w_accept && (in_last != w_cnt_last);
            if (w_accept) begin
                r_cnt   <= w_cnt_last ? '0 : r_cnt + 1'b1;
                wr_bank <= w_fill_bank;
                wr_addr <= BITS_PER_ROW'(bitrev(MAX_BITS'(r_cnt), BITS_PER_ROW));
                wr_re   <= in_re;
                wr_im   <= in_im;
            end
        end
endmodule

// File: tb/tb_fft_bitrev_loader.sv
// tb_fft_bitrev_loader: table and scoreboard driven bench for the FFT bit-reversal loader.
module tb_fft_bitrev_loader;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, frame_ack = 1'b0;
    logic [15:0] in_re = '0, in_im = '0;
    logic        in_ready, wr_en, wr_bank, frame_valid, frame_bank, frame_err;
    logic [2:0]  wr_addr;
    logic [15:0] wr_re, wr_im;

    typedef struct {
        logic [15:0] re;
        logic        last;
        logic [2:0]  addr;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        bank;
        logic [2:0]  addr;
        logic [15:0] re;
        logic [15:0] im;
        logic        err;
    } exp_t;

    vec_t  tab [8];
    exp_t  q [$];
    exp_t  mon_e;
    int    total = 0, bad = 0, cyc = 0, m_cnt = 0;
    logic  m_fill = 1'b0;

    fft_bitrev_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_ack(frame_ack),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [2:0] rev3(input logic [2:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    always @(negedge clk)
        if (!rst) begin
            if (wr_en) begin
                if (q.size() == 0) chk("wr_en_spurious", wr_en, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_bank", wr_bank, mon_e.bank);
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_re", wr_re, mon_e.re);
                    chk("wr_im", wr_im, mon_e.im);
                    chk("frame_err", frame_err, mon_e.err);
                end
            end else chk("err_idle", frame_err, 0);
        end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [15:0] re, input logic last, input logic [2:0] xaddr);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = re ^ 16'hA5A5;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", in_ready, 1);
        e = '{cyc + 1, m_fill, xaddr, re, re ^ 16'hA5A5, last != (m_cnt == 7)};
        q.push_back(e);
        if (m_cnt == 7) begin
            m_cnt  = 0;
            m_fill = !m_fill;
        end else m_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic beat_m(input int re, input logic last);
        beat(16'(re), last, rev3(3'(m_cnt)));
    endtask

    task automatic ack_pulse();
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
    endtask

    task automatic rst_dut();
        rst       = 1'b1;
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        step(1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_bank", frame_bank, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_re", wr_re, 0);
        chk("rst_wr_im", wr_im, 0);
        rst = 1'b0;
        q.delete();
        m_cnt  = 0;
        m_fill = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{16'd0, 1'b0, 3'd0};
        tab[1] = '{16'd1, 1'b0, 3'd4};
        tab[2] = '{16'd2, 1'b0, 3'd2};
        tab[3] = '{16'd3, 1'b0, 3'd6};
        tab[4] = '{16'd4, 1'b0, 3'd1};
        tab[5] = '{16'd5, 1'b0, 3'd5};
        tab[6] = '{16'd6, 1'b0, 3'd3};
        tab[7] = '{16'd7, 1'b1, 3'd7};

        rst_dut();
        for (int i = 0; i < 8; i++) beat(tab[i].re, tab[i].last, tab[i].addr);
        chk("basic_fv_early", frame_valid, 0);
        step(1);
        chk("basic_fv", frame_valid, 1);
        chk("basic_fb", frame_bank, 0);
        ack_pulse();
        chk("basic_fv_acked", frame_valid, 0);
        chk("basic_fb_acked", frame_bank, 1);

        rst_dut();
        for (int i = 0; i < 16; i++) beat_m(i, i % 8 == 7);
        chk("stall_ready_drop", in_ready, 0);
        step(1);
        chk("stall_fv", frame_valid, 1);
        chk("stall_fb", frame_bank, 0);
        chk("stall_ready_held", in_ready, 0);
        ack_pulse();
        chk("stall_fb_after_ack", frame_bank, 1);
        chk("stall_fv_after_ack", frame_valid, 1);
        chk("stall_ready_after_ack", in_ready, 1);
        for (int i = 16; i < 24; i++) beat_m(i, i % 8 == 7);
        step(2);
        chk("stall_fb_end", frame_bank, 1);
        chk("stall_ready_end", in_ready, 0);

        rst_dut();
        for (int i = 0; i < 8; i++) begin
            beat_m(100 + i, i == 7);
            chk("gap_fv_early", frame_valid, 0);
            step(1);
        end
        chk("gap_fv", frame_valid, 1);

        rst_dut();
        for (int i = 0; i < 8; i++) beat_m(200 + i, i == 5);
        step(1);
        chk("ferr_fv", frame_valid, 1);
        chk("ferr_fb", frame_bank, 0);

        rst_dut();
        for (int i = 0; i < 8; i++) beat_m(300 + i, i == 7);
        step(1);
        chk("sim_fv0", frame_valid, 1);
        chk("sim_fb0", frame_bank, 0);
        for (int i = 8; i < 16; i++) beat_m(300 + i, i == 15);
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
        chk("sim_fv1", frame_valid, 1);
        chk("sim_fb1", frame_bank, 1);
        chk("sim_ready", in_ready, 1);

        rst_dut();
        for (int i = 0; i < 3; i++) beat_m(400 + i, 1'b0);
        rst_dut();
        for (int i = 0; i < 8; i++) beat_m(500 + i, i == 7);
        chk("mid_rst_fv_early", frame_valid, 0);
        step(1);
        chk("mid_rst_fv", frame_valid, 1);
        chk("mid_rst_fb", frame_bank, 0);

        step(2);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Input stage of the FFT datapath.
- Accepts complex samples in natural order over a valid/ready stream.
- Writes each sample into the ping-pong sample memory at its bit-reversed address, alternating banks per frame.
- Hands each completed frame to the butterfly engine through a frame_valid/frame_ack handshake, and stalls the input while both banks hold unconsumed frames.

Parameters:
N, 8, transform length; power of two, N >= 4
BITS_PER_ROW, 3, log2(N); width of a bank address
DATA_W, 16, width of each real/imaginary sample component

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  sample present on in_re/in_im
in_ready  output  1  loader can accept a sample this cycle
in_re  input  DATA_W  real part
in_im  input  DATA_W  imaginary part
in_last  input  1  marks final sample of a frame (checked only)
wr_en  output  1  memory write strobe
wr_bank  output  1  target bank (0/1)
wr_addr  output  BITS_PER_ROW  bit-reversed write address
wr_re  output  DATA_W  write data, real
wr_im  output  DATA_W  write data, imaginary
frame_valid  output  1  a full bank is ready for the FFT engine
frame_bank  output  1  bank holding the oldest ready frame
frame_ack  input  1  engine has consumed frame_bank
frame_err  output  1  one-cycle pulse on in_last mismatch

Behaviour:
- Reset (sync, active-high):
  - All outputs 0: in_ready=0 during rst, then 1 from the first cycle after.
  - cnt=0, fill_bank=0, read_bank=0, full[1:0]=0, pending=0.
  - Any partial frame is discarded; any pending frame is dropped.
- Accept:
  - Beat accepted when in_valid && in_ready.
  - in_ready = !rst && !full[fill_bank].
  - Purely registered; no combinational path from in_valid to in_ready.
- Write latency:
  - Beat accepted in cycle T drives wr_en=1 in T+1.
  - wr_bank=fill_bank at T; wr_addr=bitrev(cnt at T), i.e. bit i of cnt maps to bit BITS_PER_ROW-1-i.
  - wr_re/wr_im are registered copies of the inputs.
  - wr_en=0 in cycles with no accepted beat at T.
- Counter:
  - cnt increments per accepted beat.
  - On acceptance with cnt==N-1: cnt wraps to 0, fill_bank toggles (visible in T+1), and pending records the completed bank.
- Frame completion: full[completed bank] sets at the end of T+1, so frame_valid can first rise in T+2, after the last write has landed.
- Output:
  - frame_valid = full[read_bank]; frame_bank = read_bank.
  - frame_ack with frame_valid=1 clears full[read_bank] and toggles read_bank on the same edge.
  - frame_ack with frame_valid=0 is ignored.
- Simultaneous events:
  - Completion of one bank and ack of the other in the same cycle: both take effect.
  - A bank cannot be both filled and acked in one cycle, because in_ready=0 while it is full.
- Backpressure: when both banks are full, in_ready=0 until an ack frees read_bank; the freed bank is the next fill_bank.
- Framing:
  - frame_err pulses in T+1 if in_last=1 with cnt!=N-1, or in_last=0 with cnt==N-1, at acceptance.
  - Framing is always by count; in_last never resets cnt.
- Gaps: in_valid may drop any cycle; cnt, bank and outputs hold.

Decomposition:
- Package fft_pkg holds:
  - N and BITS_PER_ROW defaults;
  - a bitrev(addr) function;
  - a cplx_t typedef (re/im of DATA_W);
  - a bank_t 1-bit typedef.
- One sub-module, pingpong_bank_ctrl, owns:
  - full[1:0], fill_bank, read_bank and pending;
  - inputs: frame_done, frame_ack;
  - outputs: fill_bank, frame_valid, frame_bank, bank_free.
- The top holds the counter, the write pipeline register and the framing check.

Test Plan:
- Basic order: after reset, stream samples 0..7 with in_re=index, in_last on 7.
  - Expect wr_addr sequence 0,4,2,6,1,5,3,7 with wr_re=0,1,2,3,4,5,6,7.
  - Expect wr_bank=0 throughout; frame_valid=1, frame_bank=0 two cycles after the 8th accept.
- Ping-pong stall: stream 24 samples back-to-back, no ack.
  - Frames 1 and 2 go to banks 0 and 1; in_ready drops right after the 16th accept.
  - Pulse frame_ack once: bank 0 frees, frame_bank becomes 1, and samples 16..23 write to bank 0.
- Gapped input: in_valid toggles 1,0,1,0.
  - wr_en pulses only one cycle after accepts; address order unchanged; no frame_valid before the 8th accept.
- Framing error: in_last on sample 5, absent on sample 7.
  - frame_err pulses twice, one cycle after each of those accepts; the frame still completes on the 8th beat.
- Simultaneous ack/complete: bank 0 full and held. Finish bank 1 while frame_ack is high in the completion cycle T+1.
  - Bank 0 is released and bank 1 becomes full; frame_bank=1 next cycle; in_ready stays 1.
- Reset mid-frame: rst after 3 accepted samples.
  - All outputs go to 0; the next 8 samples write bank 0 from wr_addr 0; no stale frame_valid.
